// File: rtl/rock_pkg.sv
// Shared types, constants and saturating index helpers for the rocking controller.
package rock_pkg;

    localparam int IDX_W = 4;
    localparam int CNT_W = 4;
    localparam logic [IDX_W-1:0] IDX_MAX = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_EVAL   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ALARM  = 3'd4
    } rock_state_e;

    // Add step to idx, clamping at IDX_MAX instead of wrapping.
    function automatic logic [IDX_W-1:0] idx_sat_add(input logic [IDX_W-1:0] idx,
                                                     input logic [IDX_W-1:0] step);
        logic [IDX_W:0] sum;
        sum = {1'b0, idx} + {1'b0, step};
        if (sum > {1'b0, IDX_MAX}) begin
            return IDX_MAX;
        end else begin
            return sum[IDX_W-1:0];
        end
    endfunction

    // Subtract step from idx, clamping at zero instead of wrapping.
    function automatic logic [IDX_W-1:0] idx_sat_sub(input logic [IDX_W-1:0] idx,
                                                     input logic [IDX_W-1:0] step);
        if (idx < step) begin
            return 4'd0;
        end else begin
            return idx - step;
        end
    endfunction

endpackage

// File: rtl/rock_tick_counter.sv
// Loadable 4-bit down-counter advanced by the tick-qualified decrement strobe.
// Times both the settle period and the calm hold period of the scheduler.
module rock_tick_counter
    import rock_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a load wins over a decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);
    // The next decrement takes the count to zero.
    assign last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/rock_scheduler.sv
// Closed-loop rocking controller: steps a 16-level rocking setting from
// stress feedback, sampled on evaluation ticks, and flags an alarm when
// maximum rocking repeatedly fails to reduce stress.
module rock_scheduler
    import rock_pkg::*;
#(
    parameter int unsigned SETTLE_TICKS = 4,
    parameter int unsigned HOLD_TICKS   = 8,
    parameter int unsigned CALM_LEVEL   = 1,
    parameter int unsigned MAX_FAIL     = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic [2:0] status_i,
    input  logic       gedaald_i,
    input  logic       gelijk_i,
    output logic       rocking_o,
    output logic [1:0] freq_o,
    output logic [1:0] ampl_o,
    output logic       alarm_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] SETTLE_LD = SETTLE_TICKS[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HOLD_LD   = HOLD_TICKS[CNT_W-1:0];
    localparam logic [2:0]       CALM_LD   = CALM_LEVEL[2:0];
    localparam logic [2:0]       FAIL_LD   = MAX_FAIL[2:0];

    rock_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic             rocking_q;
    logic             alarm_q;

    // Feedback captured on the most recent settle tick, judged in EVAL.
    logic [2:0]       samp_status_q;
    logic             samp_gedaald_q;
    logic             samp_gelijk_q;
    logic             samp_en_s;

    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;
    logic             cnt_last_s;
    logic             cnt_done_s;

    logic             calm_now_s;
    logic             calm_samp_s;
    logic [2:0]       fcnt_inc_s;
    logic [IDX_W-1:0] idx_dec_s;
    logic [IDX_W-1:0] idx_step_s;

    rock_tick_counter u_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_load_val_s),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s),
        .last_o     (cnt_last_s)
    );

    assign cnt_done_s  = cnt_last_s || cnt_zero_s;
    assign calm_now_s  = (status_i <= CALM_LD);
    assign calm_samp_s = (samp_status_q <= CALM_LD);
    assign fcnt_inc_s  = fcnt_q + 3'd1;
    assign idx_dec_s   = idx_sat_sub(idx_q, 4'd1);

    // Setting after an evaluation: hold on decrease, +1 on equal, +2 on increase.
    always_comb begin
        idx_step_s = idx_q;
        if (samp_gedaald_q) begin
            idx_step_s = idx_q;
        end else if (samp_gelijk_q) begin
            idx_step_s = idx_sat_add(idx_q, 4'd1);
        end else begin
            idx_step_s = idx_sat_add(idx_q, 4'd2);
        end
    end

    // Next-state, setting, fail-count and counter control for the controller FSM.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        fcnt_d         = fcnt_q;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = 4'd0;
        cnt_dec_s      = 1'b0;
        samp_en_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_i && !calm_now_s) begin
                    idx_d          = 4'd1;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = SETTLE_LD;
                    state_d        = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (tick_i) begin
                    samp_en_s = 1'b1;
                    cnt_dec_s = 1'b1;
                    if (cnt_done_s) begin
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_EVAL: begin
                // Ticks are ignored here; only the captured sample matters.
                if (calm_samp_s) begin
                    fcnt_d         = 3'd0;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = HOLD_LD;
                    state_d        = ST_HOLD;
                end else if ((idx_q == IDX_MAX) && !samp_gedaald_q && (fcnt_inc_s >= FAIL_LD)) begin
                    // Maximum rocking has failed too often in a row.
                    fcnt_d  = 3'd0;
                    idx_d   = IDX_MAX;
                    state_d = ST_ALARM;
                end else begin
                    if ((idx_q == IDX_MAX) && !samp_gedaald_q) begin
                        fcnt_d = fcnt_inc_s;
                    end else begin
                        fcnt_d = 3'd0;
                    end
                    idx_d          = idx_step_s;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = SETTLE_LD;
                    state_d        = ST_SETTLE;
                end
            end
            ST_HOLD: begin
                if (tick_i) begin
                    if (!calm_now_s) begin
                        // Stress is back: abandon the hold period at the current setting.
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = SETTLE_LD;
                        state_d        = ST_SETTLE;
                    end else if (cnt_done_s) begin
                        idx_d = idx_dec_s;
                        if (idx_dec_s == 4'd0) begin
                            cnt_dec_s = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            cnt_load_s     = 1'b1;
                            cnt_load_val_s = HOLD_LD;
                            state_d        = ST_HOLD;
                        end
                    end else begin
                        cnt_dec_s = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_ALARM: begin
                idx_d = IDX_MAX;
                if (tick_i && calm_now_s) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = HOLD_LD;
                    state_d        = ST_HOLD;
                end else begin
                    state_d = ST_ALARM;
                end
            end
            default: begin
                idx_d   = 4'd0;
                fcnt_d  = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; outputs are derived from next-state so they are registered.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            fcnt_q    <= 3'd0;
            rocking_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fcnt_q    <= fcnt_d;
            rocking_q <= (idx_d != 4'd0);
            alarm_q   <= (state_d == ST_ALARM);
        end
    end

    // Capture the stress feedback on every settle tick.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            samp_status_q  <= 3'd0;
            samp_gedaald_q <= 1'b0;
            samp_gelijk_q  <= 1'b0;
        end else if (samp_en_s) begin
            samp_status_q  <= status_i;
            samp_gedaald_q <= gedaald_i;
            samp_gelijk_q  <= gelijk_i;
        end else begin
            samp_status_q  <= samp_status_q;
            samp_gedaald_q <= samp_gedaald_q;
            samp_gelijk_q  <= samp_gelijk_q;
        end
    end

    assign rocking_o = rocking_q;
    assign freq_o    = idx_q[3:2];
    assign ampl_o    = idx_q[1:0];
    assign alarm_o   = alarm_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rock_scheduler.sv
// Scoreboard bench for rock_scheduler: directed stimulus queues the expected
// outputs for the following cycle; a monitor pops and compares them.
module tb_rock_scheduler;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_ALARM  = 3'd4;

    logic       clk_i;
    logic       reset_i;
    logic       tick_i;
    logic [2:0] status_i;
    logic       gedaald_i;
    logic       gelijk_i;
    logic       rocking_o;
    logic [1:0] freq_o;
    logic [1:0] ampl_o;
    logic       alarm_o;
    logic [2:0] state_o;

    rock_scheduler #(
        .SETTLE_TICKS (4),
        .HOLD_TICKS   (8),
        .CALM_LEVEL   (1),
        .MAX_FAIL     (3)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .tick_i    (tick_i),
        .status_i  (status_i),
        .gedaald_i (gedaald_i),
        .gelijk_i  (gelijk_i),
        .rocking_o (rocking_o),
        .freq_o    (freq_o),
        .ampl_o    (ampl_o),
        .alarm_o   (alarm_o),
        .state_o   (state_o)
    );

    typedef struct {
        int         due;
        string      tag;
        logic [8:0] want;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // {rocking, freq, ampl, alarm, state}
    function automatic logic [8:0] pack(input logic [3:0] idx, input logic al, input logic [2:0] st);
        return {(idx != 4'd0), idx, al, st};
    endfunction

    task automatic compare(input string tag, input logic [8:0] want);
        logic [8:0] got;
        got = {rocking_o, freq_o, ampl_o, alarm_o, state_o};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got rocking=%0b idx=%0d alarm=%0b state=%0d, want rocking=%0b idx=%0d alarm=%0b state=%0d",
                     tag, got[8], got[7:4], got[3], got[2:0], want[8], want[7:4], want[3], want[2:0]);
        end
    endtask

    task automatic expect_next(input string tag, input logic [3:0] idx, input logic al, input logic [2:0] st);
        exp_t e;
        e.due  = cyc + 1;
        e.tag  = tag;
        e.want = pack(idx, al, st);
        sb.push_back(e);
    endtask

    task automatic step(input logic t, input logic [2:0] st, input logic gd, input logic gl);
        tick_i    = t;
        status_i  = st;
        gedaald_i = gd;
        gelijk_i  = gl;
        @(negedge clk_i);
    endtask

    // Four settle ticks with the given feedback, then the EVAL cycle (with a stray tick).
    task automatic run_eval(input string tag, input logic [2:0] st, input logic gd, input logic gl,
                            input logic [3:0] idx_now, input logic [3:0] idx_after,
                            input logic [2:0] st_after, input logic al_after, input logic gap);
        for (int k = 1; k <= 4; k++) begin
            if (gap) begin
                expect_next({tag, "_gap"}, idx_now, 1'b0, S_SETTLE);
                step(1'b0, 3'd7, 1'b1, 1'b0);
            end
            expect_next({tag, "_settle"}, idx_now, 1'b0, (k < 4) ? S_SETTLE : S_EVAL);
            step(1'b1, st, gd, gl);
        end
        expect_next({tag, "_decide"}, idx_after, al_after, st_after);
        step(1'b1, 3'd0, 1'b1, 1'b0);
    endtask

    // Eight calm ticks in HOLD: the setting steps down by one on the eighth.
    task automatic hold_down(input logic [3:0] idx_now);
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) begin
                expect_next("hold_count", idx_now, 1'b0, S_HOLD);
            end else begin
                expect_next("hold_step", idx_now - 4'd1, 1'b0, (idx_now == 4'd1) ? S_IDLE : S_HOLD);
            end
            step(1'b1, (k % 2 == 1) ? 3'd1 : 3'd0, 1'b0, 1'b0);
        end
    endtask

    // Monitor: after each rising edge, compare every expectation due by now.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                compare(mon_e.tag, mon_e.want);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want sequence end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i   = 1'b1;
        tick_i    = 1'b0;
        status_i  = 3'd0;
        gedaald_i = 1'b0;
        gelijk_i  = 1'b0;
        #3 reset_i = 1'b0;
        #1 compare("reset_state", pack(4'd0, 1'b0, S_IDLE));
        @(negedge clk_i);
        expect_next("reset_low", 4'd0, 1'b0, S_IDLE);
        step(1'b1, 3'd7, 1'b0, 1'b0);
        reset_i = 1'b1;

        // Calm tick in IDLE does nothing; stressed tick starts rocking.
        expect_next("idle_calm", 4'd0, 1'b0, S_IDLE);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        expect_next("idle_start", 4'd1, 1'b0, S_SETTLE);
        step(1'b1, 3'd5, 1'b0, 1'b0);

        run_eval("equal_1to2", 3'd5, 1'b0, 1'b1, 4'd1, 4'd2, S_SETTLE, 1'b0, 1'b0);
        run_eval("inc_2to4",   3'd6, 1'b0, 1'b0, 4'd2, 4'd4, S_SETTLE, 1'b0, 1'b0);
        run_eval("inc_gap",    3'd6, 1'b0, 1'b0, 4'd4, 4'd6, S_SETTLE, 1'b0, 1'b1);

        // Reset in the middle of SETTLE at idx 6.
        expect_next("settle6", 4'd6, 1'b0, S_SETTLE);
        step(1'b1, 3'd5, 1'b0, 1'b0);
        #2 reset_i = 1'b0;
        #1 compare("async_reset", pack(4'd0, 1'b0, S_IDLE));
        @(negedge clk_i);
        expect_next("reset_mid", 4'd0, 1'b0, S_IDLE);
        step(1'b1, 3'd7, 1'b0, 1'b0);
        reset_i = 1'b1;
        expect_next("after_reset", 4'd0, 1'b0, S_IDLE);
        step(1'b0, 3'd7, 1'b0, 1'b0);

        // Climb to the top of the range.
        expect_next("restart", 4'd1, 1'b0, S_SETTLE);
        step(1'b1, 3'd5, 1'b0, 1'b0);
        run_eval("inc_1to3",   3'd6, 1'b0, 1'b0, 4'd1,  4'd3,  S_SETTLE, 1'b0, 1'b0);
        run_eval("inc_3to5",   3'd6, 1'b0, 1'b0, 4'd3,  4'd5,  S_SETTLE, 1'b0, 1'b0);
        run_eval("inc_5to7",   3'd6, 1'b0, 1'b0, 4'd5,  4'd7,  S_SETTLE, 1'b0, 1'b0);
        run_eval("inc_7to9",   3'd6, 1'b0, 1'b0, 4'd7,  4'd9,  S_SETTLE, 1'b0, 1'b0);
        run_eval("inc_9to11",  3'd6, 1'b0, 1'b0, 4'd9,  4'd11, S_SETTLE, 1'b0, 1'b0);
        run_eval("inc_11to13", 3'd6, 1'b0, 1'b0, 4'd11, 4'd13, S_SETTLE, 1'b0, 1'b0);
        run_eval("eq_13to14",  3'd7, 1'b0, 1'b1, 4'd13, 4'd14, S_SETTLE, 1'b0, 1'b0);
        run_eval("dec_14",     3'd6, 1'b1, 1'b0, 4'd14, 4'd14, S_SETTLE, 1'b0, 1'b0);
        run_eval("inc_sat15",  3'd6, 1'b0, 1'b0, 4'd14, 4'd15, S_SETTLE, 1'b0, 1'b0);

        // Failures at 15; a decrease clears the run, then three in a row alarm.
        run_eval("fail1",      3'd7, 1'b0, 1'b1, 4'd15, 4'd15, S_SETTLE, 1'b0, 1'b0);
        run_eval("fail2",      3'd7, 1'b0, 1'b1, 4'd15, 4'd15, S_SETTLE, 1'b0, 1'b0);
        run_eval("dec_clear",  3'd7, 1'b1, 1'b0, 4'd15, 4'd15, S_SETTLE, 1'b0, 1'b0);
        run_eval("refail1",    3'd7, 1'b0, 1'b1, 4'd15, 4'd15, S_SETTLE, 1'b0, 1'b0);
        run_eval("refail2",    3'd7, 1'b0, 1'b1, 4'd15, 4'd15, S_SETTLE, 1'b0, 1'b0);
        run_eval("alarm",      3'd7, 1'b0, 1'b1, 4'd15, 4'd15, S_ALARM,  1'b1, 1'b0);

        expect_next("alarm_stress", 4'd15, 1'b1, S_ALARM);
        step(1'b1, 3'd5, 1'b0, 1'b0);
        expect_next("alarm_notick", 4'd15, 1'b1, S_ALARM);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        expect_next("alarm_clear", 4'd15, 1'b0, S_HOLD);
        step(1'b1, 3'd0, 1'b0, 1'b0);

        // Calm hold periods walk the setting down to 3.
        for (int v = 15; v >= 4; v--) begin
            hold_down(4'(v));
        end

        // Stress returns partway through a hold period.
        for (int k = 1; k <= 5; k++) begin
            expect_next("hold3_partial", 4'd3, 1'b0, S_HOLD);
            step(1'b1, 3'd0, 1'b0, 1'b0);
        end
        expect_next("hold_abort", 4'd3, 1'b0, S_SETTLE);
        step(1'b1, 3'd4, 1'b0, 1'b0);
        run_eval("calm_eval", 3'd0, 1'b0, 1'b0, 4'd3, 4'd3, S_HOLD, 1'b0, 1'b0);

        hold_down(4'd3);
        hold_down(4'd2);
        hold_down(4'd1);

        expect_next("idle_again", 4'd0, 1'b0, S_IDLE);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        expect_next("idle_restart", 4'd1, 1'b0, S_SETTLE);
        step(1'b1, 3'd2, 1'b0, 1'b0);
        expect_next("settle_hold", 4'd1, 1'b0, S_SETTLE);
        step(1'b0, 3'd2, 1'b0, 1'b0);
        @(negedge clk_i);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rock_scheduler.md
# rock_scheduler

Closed-loop rocking controller. On each evaluation tick it reads the 3-bit stress level and the decreased/equal flags from the stress-trend block, then steps a 16-level rocking setting (frequency and amplitude) up or down. It drives the motor-control inputs and raises an alarm when maximum rocking stops reducing stress.

## Interface
Parameters:
- SETTLE_TICKS, 4: ticks to wait after a setting change before evaluating (1..15)
- HOLD_TICKS, 8: consecutive calm ticks required before stepping down (1..15)
- CALM_LEVEL, 1: stress at or below this value counts as calm (0..6)
- MAX_FAIL, 3: consecutive non-decreasing evaluations at index 15 that raise the alarm (1..7)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  evaluation strobe, one clk cycle wide
- status  in  3  stress level, 0..7
- gedaald  in  1  stress decreased versus the previous sample
- gelijk  in  1  stress unchanged for two samples
- rocking  out  1  motor enable
- freq  out  2  rocking frequency setting, idx[3:2]
- ampl  out  2  rocking amplitude setting, idx[1:0]
- alarm  out  1  maximum rocking is ineffective
- state  out  3  FSM state code, for debug

## Operation
- Internal 4-bit setting index idx drives {freq, ampl} = idx. rocking = (idx != 0).
- Inputs are sampled only in cycles with tick = 1. All other cycles hold state, apart from the async reset.
- Calm means status <= CALM_LEVEL.
- Each evaluation is classified as:
  - increased: !gedaald && !gelijk
  - equal: gelijk
  - decreased: gedaald
- FSM states and codes:
  - IDLE (0): on tick, if not calm, set idx = 1, load cnt = SETTLE_TICKS, go to SETTLE.
  - SETTLE (1): on each tick, decrement cnt. On the tick where cnt reaches 0, go to EVAL.
  - EVAL (2): single cycle, no tick needed. The status/gedaald/gelijk values used are those registered at the last SETTLE tick. Decisions:
    - calm: load cnt = HOLD_TICKS, go to HOLD.
    - decreased: idx unchanged, reload settle counter, go to SETTLE.
    - equal: idx = idx + 1, saturating at 15, reload settle counter, go to SETTLE.
    - increased: idx = idx + 2, saturating at 15, reload settle counter, go to SETTLE.
  - HOLD (3): on tick, if not calm, reload settle counter, go to SETTLE with idx unchanged. On a calm tick, decrement cnt. When cnt reaches 0, idx = idx - 1. If the new idx is 0, go to IDLE; otherwise reload HOLD_TICKS and stay in HOLD.
  - ALARM (4): alarm = 1, idx held at 15. On a calm tick, clear alarm, load HOLD_TICKS, go to HOLD.
- Fail counter fcnt (3 bits):
  - In EVAL with idx == 15 before the update and a non-decreased, non-calm result: fcnt increments.
  - Any other EVAL result clears fcnt.
  - When fcnt reaches MAX_FAIL, go to ALARM instead of SETTLE and clear fcnt.
- Saturation: idx never wraps, in either direction.

## Timing
- Reset values: rocking = 0, freq = 0, ampl = 0, alarm = 0, state = IDLE, idx = 0, cnt = 0, fcnt = 0.
- All outputs are registered. The effect of a tick appears one clk cycle after the tick cycle.
- An EVAL decision appears one cycle after entering EVAL, which is 2 cycles after the final SETTLE tick.
- A tick that arrives in the EVAL cycle is ignored. Back-to-back ticks are otherwise all honoured.
- Reset asserted mid-operation forces all registers to reset values immediately. Deassertion takes effect at the next clk edge.

## Structure
- Shared package rock_pkg holds:
  - the state enum (IDLE, SETTLE, EVAL, HOLD, ALARM, 3-bit encoding)
  - IDX_W = 4 and IDX_MAX = 15
  - the saturating add/subtract functions for idx
- Sub-module rock_tick_counter: 4-bit loadable down-counter, advanced on tick, with a zero flag. Used for both the settle and hold periods.

## Test plan
- Reset during SETTLE with idx = 6 -> all outputs go to 0 asynchronously, state = 0.
- From IDLE, status = 5 on a tick -> next cycle idx = 1, rocking = 1, state = SETTLE. After 4 more ticks with gelijk = 1 -> EVAL, then idx = 2.
- Increase case at idx = 14: gedaald = 0, gelijk = 0, status = 6 -> idx saturates at 15, not 0.
- At idx = 15, three evaluations with gelijk = 1 and status = 7 -> alarm = 1, state = ALARM. A calm tick (status = 0) -> alarm = 0, state = HOLD.
- In HOLD at idx = 2 with status = 0: 8 ticks -> idx = 1; 8 more ticks -> idx = 0, rocking = 0, state = IDLE.
- In HOLD at idx = 3 after 5 calm ticks, then status = 4 on a tick -> state = SETTLE, idx stays 3, hold count discarded.
